// File: rtl/register_dump_streamer_pkg.sv
// Shared types and constants for the register dump streamer and its snapshot buffer.
package register_dump_streamer_pkg;

    localparam int unsigned REG_COUNT_DEFAULT  = 32;
    localparam int unsigned WORD_WIDTH_DEFAULT = 32;
    localparam int unsigned IDX_W              = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_e;

endpackage

// File: rtl/register_snapshot_buffer.sv
// Wide one-cycle capture of the packed register bus, read back one word at a time.
module register_snapshot_buffer
    import register_dump_streamer_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEFAULT,
    parameter int unsigned REG_COUNT  = REG_COUNT_DEFAULT
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            load_i,
    input  logic [REG_COUNT*WORD_WIDTH-1:0] bus_i,
    input  logic [IDX_W-1:0]                index_i,
    output logic [WORD_WIDTH-1:0]           data_o
);

    logic [WORD_WIDTH-1:0] snap_q [REG_COUNT];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < REG_COUNT; k++) begin
                snap_q[k] <= '0;
            end
        end else if (load_i) begin
            for (int unsigned k = 0; k < REG_COUNT; k++) begin
                snap_q[k] <= bus_i[k*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    assign data_o = snap_q[index_i];

endmodule

// File: rtl/register_dump_streamer.sv
// Snapshots the register file on start and streams it out one register per valid/ready beat.
module register_dump_streamer
    import register_dump_streamer_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEFAULT,
    parameter int unsigned REG_COUNT  = REG_COUNT_DEFAULT,
    parameter int unsigned SKIP_ZERO  = 1
) (
    input  logic                            clock,
    input  logic                            resetN,
    input  logic [REG_COUNT*WORD_WIDTH-1:0] debugRegisters,
    input  logic                            start,
    input  logic                            abort,
    input  logic                            outReady,
    output logic                            outValid,
    output logic [WORD_WIDTH-1:0]           outData,
    output logic [IDX_W-1:0]                outIndex,
    output logic                            outLast,
    output logic                            busy,
    output logic                            done
);

    localparam logic [IDX_W-1:0] FIRST_IDX = (SKIP_ZERO != 0) ? IDX_W'(1) : IDX_W'(0);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(REG_COUNT - 1);

    dump_state_e           state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  load;
    logic [WORD_WIDTH-1:0] snap_word;

    register_snapshot_buffer #(
        .WORD_WIDTH (WORD_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_snapshot (
        .clk_i   (clock),
        .rst_ni  (resetN),
        .load_i  (load),
        .bus_i   (debugRegisters),
        .index_i (idx_q),
        .data_o  (snap_word)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        load     = 1'b0;
        outValid = 1'b0;
        outLast  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        outIndex = idx_q;
        outData  = '0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = SEND;
                    idx_d   = FIRST_IDX;
                    load    = 1'b1;
                end
            end
            SEND: begin
                outValid = 1'b1;
                busy     = 1'b1;
                outData  = snap_word;
                outLast  = (idx_q == LAST_IDX);
                // An abort drops the beat on offer even if outReady is high.
                if (abort) begin
                    state_d = IDLE;
                end else if (outReady) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = !abort;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_register_dump_streamer.sv
// Scoreboard bench for register_dump_streamer: SKIP_ZERO=1 and SKIP_ZERO=0 instances.
module tb_register_dump_streamer;

    localparam int unsigned WW = 32;
    localparam int unsigned RC = 32;

    typedef struct packed {
        logic [4:0]    idx;
        logic [WW-1:0] data;
        logic          last;
    } beat_t;

    logic           clock = 1'b0;
    logic           resetN = 1'b0;
    logic [RC*WW-1:0] bus = '0;
    logic           start_a = 1'b0, start_b = 1'b0, abort = 1'b0, ready = 1'b0;
    logic           valid_a, last_a, busy_a, done_a;
    logic           valid_b, last_b, busy_b, done_b;
    logic [WW-1:0]  data_a, data_b;
    logic [4:0]     idx_a, idx_b;

    logic           sel = 1'b0;
    logic           v_s, l_s, b_s, dn_s;
    logic [WW-1:0]  d_s;
    logic [4:0]     i_s;

    logic [WW-1:0]  regs [RC];
    beat_t          exp_q [$];
    int             n_cmp = 0;
    int             n_err = 0;

    always #5 clock = ~clock;

    register_dump_streamer #(.WORD_WIDTH(WW), .REG_COUNT(RC), .SKIP_ZERO(1)) dut_a (
        .clock(clock), .resetN(resetN), .debugRegisters(bus), .start(start_a),
        .abort(abort), .outReady(ready), .outValid(valid_a), .outData(data_a),
        .outIndex(idx_a), .outLast(last_a), .busy(busy_a), .done(done_a)
    );

    register_dump_streamer #(.WORD_WIDTH(WW), .REG_COUNT(RC), .SKIP_ZERO(0)) dut_b (
        .clock(clock), .resetN(resetN), .debugRegisters(bus), .start(start_b),
        .abort(abort), .outReady(ready), .outValid(valid_b), .outData(data_b),
        .outIndex(idx_b), .outLast(last_b), .busy(busy_b), .done(done_b)
    );

    assign v_s  = sel ? valid_b : valid_a;
    assign l_s  = sel ? last_b  : last_a;
    assign b_s  = sel ? busy_b  : busy_a;
    assign dn_s = sel ? done_b  : done_a;
    assign d_s  = sel ? data_b  : data_a;
    assign i_s  = sel ? idx_b   : idx_a;

    task automatic drive_bus();
        for (int k = 0; k < int'(RC); k++) bus[k*WW +: WW] = regs[k];
    endtask

    // Called at posedge+1; the start is captured on the next edge, together with the bus.
    task automatic pulse_start(input bit which);
        beat_t b;
        int first = which ? 0 : 1;
        for (int k = first; k < int'(RC); k++) begin
            b.idx  = 5'(k);
            b.data = regs[k];
            b.last = (k == int'(RC) - 1);
            exp_q.push_back(b);
        end
        if (which) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic drain(input int mode, input int restart_at, output int beats, output int dones);
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit prev_last_xfer = 1'b0;
        bit fin = 1'b0;
        int cyc = 0;
        beats = 0;
        dones = 0;
        ready = (mode == 0) ? 1'b1 : pat[0];
        while (!fin && cyc < 200) begin
            @(negedge clock);
            n_cmp++;
            if (v_s && dn_s) begin
                n_err++;
                $display("FAIL overlap: outValid=%b done=%b, required not both high", v_s, dn_s);
            end
            if (v_s) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_beat: idx=%0d data=%h, required no beat", i_s, d_s);
                end else begin
                    if ({i_s, d_s, l_s} !== {exp_q[0].idx, exp_q[0].data, exp_q[0].last}) begin
                        n_err++;
                        $display("FAIL beat: idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                                 i_s, d_s, l_s, exp_q[0].idx, exp_q[0].data, exp_q[0].last);
                    end
                    if (ready) begin
                        void'(exp_q.pop_front());
                        beats++;
                    end
                end
                n_cmp++;
                if (b_s !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy_send: busy=%b, required 1", b_s);
                end
            end
            if (dn_s) begin
                dones++;
                fin = 1'b1;
                n_cmp++;
                if (!prev_last_xfer) begin
                    n_err++;
                    $display("FAIL done_timing: done=1 without last beat on previous edge, required last transfer first");
                end
                n_cmp++;
                if (exp_q.size() != 0) begin
                    n_err++;
                    $display("FAIL lost_beats: %0d outstanding at done, required 0", exp_q.size());
                end
            end
            prev_last_xfer = v_s && ready && l_s;
            @(posedge clock); #1;
            start_a = 1'b0;
            start_b = 1'b0;
            cyc++;
            if (cyc == restart_at) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end
            ready = (mode == 0) ? 1'b1 : pat[cyc % 4];
        end
        if (!fin) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: no done within 200 cycles, %0d beats outstanding", exp_q.size());
        end
        ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            n_cmp++;
            if ({v_s, b_s, dn_s} !== 3'b000) begin
                n_err++;
                $display("FAIL post_idle: valid/busy/done=%b, required 000", {v_s, b_s, dn_s});
            end
            @(posedge clock); #1;
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({valid_a, last_a, busy_a, done_a, idx_a, data_a} !== '0) begin
            n_err++;
            $display("FAIL reset_a: v=%b l=%b b=%b d=%b idx=%0d data=%h, required all 0",
                     valid_a, last_a, busy_a, done_a, idx_a, data_a);
        end
        n_cmp++;
        if ({valid_b, last_b, busy_b, done_b, idx_b, data_b} !== '0) begin
            n_err++;
            $display("FAIL reset_b: v=%b l=%b b=%b d=%b idx=%0d data=%h, required all 0",
                     valid_b, last_b, busy_b, done_b, idx_b, data_b);
        end
        @(posedge clock); #1;
        resetN = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_full_dump();
        int beats, dones;
        sel = 1'b0;
        ready = 1'b1;
        pulse_start(1'b0);
        n_cmp++;
        if ({valid_a, busy_a, idx_a} !== {1'b1, 1'b1, 5'd1}) begin
            n_err++;
            $display("FAIL first_beat: valid=%b busy=%b idx=%0d, required 1 1 1", valid_a, busy_a, idx_a);
        end
        drain(0, -1, beats, dones);
        n_cmp++;
        if (beats != 31 || dones != 1) begin
            n_err++;
            $display("FAIL full_counts: beats=%0d dones=%0d, required 31 1", beats, dones);
        end
    endtask

    task automatic test_stall();
        int beats, dones;
        sel = 1'b0;
        ready = 1'b1;
        pulse_start(1'b0);
        drain(1, -1, beats, dones);
        n_cmp++;
        if (beats != 31 || dones != 1) begin
            n_err++;
            $display("FAIL stall_counts: beats=%0d dones=%0d, required 31 1", beats, dones);
        end
    endtask

    task automatic test_isolation();
        int beats, dones;
        sel = 1'b0;
        ready = 1'b1;
        pulse_start(1'b0);
        bus[5*WW +: WW] = 32'hDEAD_BEEF;
        drain(0, -1, beats, dones);
        n_cmp++;
        if (beats != 31) begin
            n_err++;
            $display("FAIL isolation_counts: beats=%0d, required 31", beats);
        end
        drive_bus();
    endtask

    task automatic test_abort();
        int beats, dones;
        bit reached = 1'b0;
        sel = 1'b0;
        ready = 1'b1;
        pulse_start(1'b0);
        for (int c = 0; c < 40 && !reached; c++) begin
            @(negedge clock);
            if (v_s && exp_q.size() != 0) begin
                n_cmp++;
                if ({i_s, d_s} !== {exp_q[0].idx, exp_q[0].data}) begin
                    n_err++;
                    $display("FAIL abort_pre: idx=%0d data=%h, required idx=%0d data=%h",
                             i_s, d_s, exp_q[0].idx, exp_q[0].data);
                end
                reached = (exp_q[0].idx == 5'd9);
                void'(exp_q.pop_front());
            end
            @(posedge clock); #1;
        end
        if (!reached) begin
            n_cmp++;
            n_err++;
            $display("FAIL abort_timeout: index 9 never transferred, required within 40 cycles");
        end
        ready = 1'b0;
        abort = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({v_s, i_s, d_s} !== {1'b1, 5'd10, regs[10]}) begin
            n_err++;
            $display("FAIL abort_stalled: valid=%b idx=%0d data=%h, required 1 10 %h", v_s, i_s, d_s, regs[10]);
        end
        @(posedge clock); #1;
        abort = 1'b0;
        ready = 1'b1;
        exp_q.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            n_cmp++;
            if ({v_s, b_s, dn_s} !== 3'b000) begin
                n_err++;
                $display("FAIL abort_idle: valid/busy/done=%b, required 000", {v_s, b_s, dn_s});
            end
            @(posedge clock); #1;
        end
        start_a = 1'b1;
        abort = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        abort = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({v_s, b_s} !== 2'b00) begin
            n_err++;
            $display("FAIL abort_priority: valid/busy=%b, required 00", {v_s, b_s});
        end
        @(posedge clock); #1;
        pulse_start(1'b0);
        drain(0, -1, beats, dones);
        n_cmp++;
        if (beats != 31 || dones != 1) begin
            n_err++;
            $display("FAIL abort_restart: beats=%0d dones=%0d, required 31 1", beats, dones);
        end
    endtask

    task automatic test_reset_mid();
        int beats, dones;
        bit reached = 1'b0;
        sel = 1'b0;
        ready = 1'b1;
        pulse_start(1'b0);
        for (int c = 0; c < 40 && !reached; c++) begin
            @(negedge clock);
            if (v_s && i_s == 5'd20) begin
                reached = 1'b1;
            end else begin
                if (v_s && exp_q.size() != 0) void'(exp_q.pop_front());
                @(posedge clock); #1;
            end
        end
        if (!reached) begin
            n_cmp++;
            n_err++;
            $display("FAIL reset_mid_timeout: index 20 never presented, required within 40 cycles");
        end
        resetN = 1'b0;
        #1;
        n_cmp++;
        if ({valid_a, last_a, busy_a, done_a, idx_a, data_a} !== '0) begin
            n_err++;
            $display("FAIL reset_mid: v=%b l=%b b=%b d=%b idx=%0d data=%h, required all 0",
                     valid_a, last_a, busy_a, done_a, idx_a, data_a);
        end
        @(posedge clock); #1;
        resetN = 1'b1;
        exp_q.delete();
        @(negedge clock);
        n_cmp++;
        if ({valid_a, busy_a, done_a} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_release: valid/busy/done=%b, required 000", {valid_a, busy_a, done_a});
        end
        @(posedge clock); #1;
        pulse_start(1'b0);
        drain(0, -1, beats, dones);
        n_cmp++;
        if (beats != 31 || dones != 1) begin
            n_err++;
            $display("FAIL reset_restart: beats=%0d dones=%0d, required 31 1", beats, dones);
        end
    endtask

    task automatic test_skip_zero_off();
        int beats, dones;
        sel = 1'b1;
        ready = 1'b1;
        pulse_start(1'b1);
        drain(0, 5, beats, dones);
        n_cmp++;
        if (beats != 32 || dones != 1) begin
            n_err++;
            $display("FAIL noskip_counts: beats=%0d dones=%0d, required 32 1", beats, dones);
        end
        sel = 1'b0;
    endtask

    initial begin
        regs[0] = '0;
        for (int k = 1; k < int'(RC); k++) regs[k] = 32'h1000_0000 + 32'(k);
        drive_bus();
        test_reset();
        test_full_dump();
        test_stall();
        test_isolation();
        test_abort();
        test_reset_mid();
        test_skip_zero_off();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/register_dump_streamer.md
# register_dump_streamer

Reads the register file's packed debug bus and streams the architectural register contents out one word per beat over a valid/ready interface. The block sits beside the register file and feeds the debug/trace path. On a `start` request it takes a single-cycle snapshot of all registers, so the dump stays coherent while the core keeps writing. It then emits each register with its index and flags the final beat.

## Interface
Parameters:
- `WORD_WIDTH`, 32: register width in bits.
- `REG_COUNT`, 32: number of architectural registers. Index width is log2(REG_COUNT) = 5.
- `SKIP_ZERO`, 1: when 1, register 0 is not emitted and the first beat is index 1. When 0, the first beat is index 0.

Ports:
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `debugRegisters`  in  REG_COUNT*WORD_WIDTH  packed register bus. Register k occupies bits [k*WORD_WIDTH +: WORD_WIDTH]; the register 0 slot reads 0.
- `start`  in  1  dump request; honoured only in IDLE.
- `abort`  in  1  cancels a dump in progress.
- `outReady`  in  1  downstream ready.
- `outValid`  out  1  beat valid.
- `outData`  out  WORD_WIDTH  snapshot value of register `outIndex`.
- `outIndex`  out  5  register index of the current beat.
- `outLast`  out  1  high on the beat with index REG_COUNT-1.
- `busy`  out  1  high in SEND and DONE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, SEND, DONE.
- IDLE → SEND when `start`=1 and `abort`=0.
  - On that edge the full `debugRegisters` is copied into the snapshot buffer.
  - The index counter loads FIRST = (SKIP_ZERO ? 1 : 0).
- SEND:
  - `outValid`=1; `outData` = snapshot[index]; `outLast` = (index == REG_COUNT-1).
  - A beat transfers on an edge where `outValid` && `outReady`.
  - A transfer of a non-last beat increments the index by 1.
  - A transfer of the last beat → DONE.
- DONE: `done`=1, `outValid`=0 for exactly one cycle, then → IDLE.
- `abort`=1 in SEND or DONE → IDLE on the next edge.
  - No `done` pulse.
  - A beat presented in that cycle is not counted; the downstream must treat it as dropped.
- `abort` has priority over `start`. `abort` in IDLE has no effect.
- `start` in SEND or DONE is ignored; it is not queued.
- Stability: while `outValid`=1 and `outReady`=0, `outData`, `outIndex` and `outLast` hold constant.
- Snapshot isolation: register file writes after the capture edge never appear in the current dump.
- The index counter never wraps. The last beat always leaves SEND, so the index never exceeds REG_COUNT-1.

## Timing
- Reset (`resetN`=0, acts immediately, asynchronously):
  - State = IDLE.
  - `outValid`, `outLast`, `busy`, `done` = 0.
  - `outIndex` = 0.
  - `outData` = 0, with the snapshot buffer cleared.
- Reset mid-dump aborts the dump with no `done` pulse.
- `start` sampled at edge N → `outValid`=1 and `busy`=1 from cycle N+1, with the first beat at index FIRST.
- Throughput: one beat per cycle while `outReady` is held high. A full dump takes REG_COUNT-FIRST SEND cycles (31 cycles with defaults), plus 1 DONE cycle.
- Last beat accepted at edge M → `done`=1 in cycle M+1 → IDLE at edge M+2. The earliest next `start` is sampled at edge M+2.
- `done` and `outValid` are never high in the same cycle.

## Structure
- Shared package holds:
  - the state enum (IDLE, SEND, DONE);
  - REG_COUNT_DEFAULT and WORD_WIDTH_DEFAULT;
  - the index-width constant (5).
- One sub-module, `register_snapshot_buffer`:
  - load-enable wide capture of the packed bus;
  - asynchronous active-low clear;
  - word-select read by index.
- The FSM, index counter and handshake logic stay in the top module.

## Test plan
- Load register k = 0x1000_0000+k (register 0 reads 0), pulse `start`, `outReady`=1 → 31 beats, indices 1..31 with data 0x1000_0001..0x1000_001F. `outLast` only at index 31. `done` one cycle after.
- Same setup with `outReady` toggling 1,0,0,1 → no beat lost or duplicated; `outData` and `outIndex` stable during each stall.
- After `start` is accepted, write register 5 to 0xDEAD_BEEF → the index 5 beat still carries the pre-start value 0x1000_0005.
- `abort` at index 10 while stalled → IDLE next cycle, `outValid`=0, no `done`. A new `start` then restarts from index 1.
- `resetN` low at index 20 → all outputs 0 immediately. After release, `busy`=0 and a `start` is accepted normally.
- SKIP_ZERO=0, `start` asserted again during SEND → 32 beats from index 0 with data 0, the repeat `start` ignored, exactly one `done`.
